msg_schedule_expander: RTL and testbench
========================================

# msg_schedule_expander

Sequential SHA-2 message-schedule expander. It accepts the 16 words of one message block over a valid/ready stream and emits the full schedule W[0..ROUNDS-1] one word per cycle. It is parametrised for SHA-256 (32-bit) and SHA-512 (64-bit), and computes both small sigma functions internally. It sits between the block padder and the compression round core.

## Interface
- WORD_W, 64: word width; only 32 (SHA-256) and 64 (SHA-512) are legal.
- ROUNDS, 80: schedule length; 64 for SHA-256, 80 for SHA-512; legal range 17..127.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_word holds the next message word.
- in_ready  output  1  expander accepts in_word this cycle (combinational).
- in_word  input  WORD_W  message word, W[0] first.
- out_valid  output  1  out_word/out_idx/out_last are valid (registered).
- out_ready  input  1  consumer takes the output word this cycle.
- out_word  output  WORD_W  schedule word W[t].
- out_idx  output  7  value of t for out_word.
- out_last  output  1  high with W[ROUNDS-1].
- busy  output  1  high from the first accepted word until W[ROUNDS-1] is issued.

## Operation
- Storage:
  - 16-entry circular buffer buf[0..15] of WORD_W bits.
  - Round counter t, 7 bits.
  - Slot pointer p = t[3:0].
- Sigma functions by width:
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
- Output register is "free" when out_valid=0 or out_ready=1.
- State LOAD (t < 16):
  - in_ready = free.
  - On an accepted word (in_valid & in_ready): buf[p] ← in_word, output register ← {in_word, t}, out_valid ← 1, t ← t+1.
  - Leave for EXPAND when t reaches 16.
- State EXPAND (16 ≤ t < ROUNDS):
  - in_ready = 0.
  - When free, compute W = σ1(buf[p+14]) + buf[p+9] + σ0(buf[p+1]) + buf[p]. Slot indices are mod 16. The sum is mod 2^WORD_W; carries are discarded.
  - Then buf[p] ← W, output register ← {W, t}, out_valid ← 1, t ← t+1.
- At t = ROUNDS-1 issue:
  - out_last ← 1.
  - t ← 0; next state LOAD.
  - busy falls the cycle after issue.
- The next block may start loading the cycle immediately after W[ROUNDS-1] is issued, subject to the output register being free.
- If free=0, nothing advances: buffer, t and output register hold, and in_ready=0.
- out_valid clears when out_ready=1 and no new word is issued that cycle.

## Timing
- Reset values:
  - out_valid=0, out_word=0, out_idx=0, out_last=0, busy=0.
  - t=0, state LOAD, all buffer entries 0.
  - in_ready=1 immediately after reset.
- Latency: 1 cycle from input acceptance to out_valid for W[0..15]. W[16] is issued in the cycle after W[15] is issued, if free.
- Throughput: with out_ready held high, one word per cycle.
  - If in_valid is also held high, a block completes ROUNDS cycles after its first accepted word.
  - Back-to-back blocks run with no bubble.
- Output stability: out_word, out_idx and out_last hold while out_valid=1 and out_ready=0.
- Reset mid-operation: the block aborts and all values return to reset. A partially issued schedule is discarded, and the consumer must drop it.
- Simultaneous out_ready=1 and a new issue: the register is overwritten in the same edge and out_valid stays 1.

## Test plan
- SHA-512 "abc" block: W0=0x6162638000000000, W1..W14=0, W15=0x18, out_ready=1.
  - W16=0x6162638000000000, W17=0x00030000000000C0.
  - out_last is asserted only at out_idx=79.
  - 80 words in 80 cycles.
- WORD_W=32, ROUNDS=64 "abc" block: W0=0x61626380, W15=0x18.
  - W16=0x61626380, W17=0x000F0000.
  - out_last at out_idx=63.
- SHA-512 σ0 check: W1=1, all other inputs 0.
  - W16=0x8100000000000000.
- Backpressure: random out_ready (50%) and random in_valid.
  - Word sequence identical to the no-stall run.
  - out_word stable while stalled.
  - in_ready=0 throughout EXPAND.
- Back-to-back: two different blocks, in_valid and out_ready held high.
  - Block 2's W[0] is issued in the cycle directly after block 1's W[79].
  - Both schedules match the golden model.
- Reset mid-run: assert rst during EXPAND at t=40.
  - Outputs return to reset values at once.
  - in_ready=1 after release.
  - A fresh block then produces a correct schedule.

Source files
------------

// File: rtl/msg_schedule_expander_if.sv
// Stream bundle between the block padder, the schedule expander and the round core.
// The slave modport is the expander's view; the master modport is the surrounding logic.
interface msg_schedule_expander_if #(
  parameter int unsigned WORD_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [6:0]        out_idx;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last, busy
  );
endinterface

// File: rtl/msg_schedule_expander.sv
// SHA-2 message-schedule expander: loads 16 words of a block, then issues W[0..ROUNDS-1]
// one word per cycle through a single registered output stage with valid/ready backpressure.
module msg_schedule_expander #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned ROUNDS = 80
) (
  input logic                    clk,
  input logic                    rst,
  msg_schedule_expander_if.slave sched
);

  localparam bit          Wide    = (WORD_W == 64);
  localparam int unsigned S0R1    = Wide ? 1  : 7;
  localparam int unsigned S0R2    = Wide ? 8  : 18;
  localparam int unsigned S0S     = Wide ? 7  : 3;
  localparam int unsigned S1R1    = Wide ? 19 : 17;
  localparam int unsigned S1R2    = Wide ? 61 : 19;
  localparam int unsigned S1S     = Wide ? 6  : 10;
  localparam logic [6:0]  LastIdx = 7'(ROUNDS - 1);

  typedef enum logic [0:0] {StLoad, StExpand} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sched_q [16];
  logic [6:0]        t_q, t_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic [6:0]        out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;

  logic              free, in_ready, issue, last;
  logic [3:0]        p, p1, p9, p14;
  logic [WORD_W-1:0] w_exp, wr_word;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, S0R1) ^ rotr(x, S0R2) ^ (x >> S0S);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, S1R1) ^ rotr(x, S1R2) ^ (x >> S1S);
  endfunction

  // Slot offsets wrap mod 16 through the 4-bit arithmetic.
  always_comb begin
    p     = t_q[3:0];
    p1    = p + 4'd1;
    p9    = p + 4'd9;
    p14   = p + 4'd14;
    w_exp = sigma1(sched_q[p14]) + sched_q[p9] + sigma0(sched_q[p1]) + sched_q[p];
  end

  always_comb begin
    free        = !out_valid_q || sched.out_ready;
    last        = (t_q == LastIdx);
    state_d     = state_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    in_ready    = 1'b0;
    issue       = 1'b0;
    wr_word     = '0;

    unique case (state_q)
      StLoad: begin
        in_ready = free;
        if (sched.in_valid && free) begin
          issue   = 1'b1;
          wr_word = sched.in_word;
          busy_d  = 1'b1;
          if (t_q == 7'd15) state_d = StExpand;
        end
      end
      StExpand: begin
        if (free) begin
          issue   = 1'b1;
          wr_word = w_exp;
          if (last) begin
            state_d = StLoad;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    if (issue) begin
      out_valid_d = 1'b1;
      out_word_d  = wr_word;
      out_idx_d   = t_q;
      out_last_d  = last;
      t_d         = last ? 7'd0 : t_q + 7'd1;
    end else if (sched.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoad;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 16; i++) sched_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      if (issue) sched_q[p] <= wr_word;
    end
  end

  assign sched.in_ready  = in_ready;
  assign sched.out_valid = out_valid_q;
  assign sched.out_word  = out_word_q;
  assign sched.out_idx   = out_idx_q;
  assign sched.out_last  = out_last_q;
  assign sched.busy      = busy_q;

endmodule

// File: tb/tb_msg_schedule_expander.sv
// Directed bench for msg_schedule_expander: SHA-512 and SHA-256 instances checked against
// hand-computed words and an independent schedule model.
module tb_msg_schedule_expander;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msg_schedule_expander_if #(.WORD_W(64)) bus64 ();
  msg_schedule_expander_if #(.WORD_W(32)) bus32 ();

  msg_schedule_expander #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk   (clk),
    .rst   (rst),
    .sched (bus64)
  );

  msg_schedule_expander #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk   (clk),
    .rst   (rst),
    .sched (bus32)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] blk   [0:63];
  logic [63:0] exp64 [0:319];
  logic [63:0] cap   [0:159];
  logic [31:0] blk32 [0:15];
  logic [31:0] exp32 [0:63];
  logic [31:0] cap32 [0:63];
  int          t_first0, t_last0, t_first1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_models();
    logic [63:0] w [80];
    logic [31:0] v [64];
    for (int b = 0; b < 4; b++) begin
      for (int t = 0; t < 80; t++) begin
        if (t < 16) w[t] = blk[b*16+t];
        else w[t] = (r64(w[t-2], 19) ^ r64(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                  + (r64(w[t-15], 1) ^ r64(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
        exp64[b*80+t] = w[t];
      end
    end
    for (int t = 0; t < 64; t++) begin
      if (t < 16) v[t] = blk32[t];
      else v[t] = (r32(v[t-2], 17) ^ r32(v[t-2], 19) ^ (v[t-2] >> 10)) + v[t-7]
                + (r32(v[t-15], 7) ^ r32(v[t-15], 18) ^ (v[t-15] >> 3)) + v[t-16];
      exp32[t] = v[t];
    end
  endtask

  // Feeds nblk blocks starting at block b0 and consumes/checks the schedule words.
  // stop_idx >= 0 returns right after that word is consumed (used for the abort test).
  task automatic run64(input int b0, input int nblk, input bit stall, input int stop_idx);
    int acc, got, cyc, nlast, t;
    bit held, in_expand;
    logic [63:0] hw;
    logic [6:0]  hi;
    logic        hl;
    acc = 0; got = 0; cyc = 0; nlast = 0; held = 0;
    while (got < nblk*80 && cyc < 3000) begin
      @(negedge clk);
      if (held) begin
        check("hold_valid", 64'(bus64.out_valid), 64'd1);
        check("hold_word", bus64.out_word, hw);
        check("hold_idx", 64'(bus64.out_idx), 64'(hi));
        check("hold_last", 64'(bus64.out_last), 64'(hl));
      end
      bus64.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (acc < nblk*16) begin
        bus64.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus64.in_word  = blk[b0*16+acc];
      end else begin
        bus64.in_valid = 1'b0;
      end
      #1;
      in_expand = (acc == 16*(nlast+1)) && !(bus64.out_valid && bus64.out_last);
      if (in_expand) check("in_ready_expand", 64'(bus64.in_ready), 64'd0);
      if (bus64.in_valid && bus64.in_ready) acc++;
      if (bus64.out_valid && bus64.out_ready) begin
        t = got % 80;
        check("word", bus64.out_word, exp64[b0*80+got]);
        check("idx", 64'(bus64.out_idx), 64'(t));
        check("last", 64'(bus64.out_last), 64'(t == 79));
        check("busy", 64'(bus64.busy), 64'(t != 79));
        cap[got] = bus64.out_word;
        if (got == 0) t_first0 = cyc;
        if (got == 79) t_last0 = cyc;
        if (got == 80) t_first1 = cyc;
        if (t == 79) nlast++;
        got++;
        held = 0;
        if (stop_idx >= 0 && got - 1 == stop_idx) return;
      end else if (bus64.out_valid) begin
        held = 1; hw = bus64.out_word; hi = bus64.out_idx; hl = bus64.out_last;
      end else begin
        held = 0;
      end
      cyc++;
    end
    bus64.in_valid = 1'b0;
    check("run64_complete", 64'(got), 64'(nblk*80));
  endtask

  task automatic run32();
    int acc, got, cyc;
    acc = 0; got = 0; cyc = 0;
    while (got < 64 && cyc < 500) begin
      @(negedge clk);
      bus32.out_ready = 1'b1;
      bus32.in_valid  = (acc < 16);
      bus32.in_word   = blk32[acc % 16];
      #1;
      if (bus32.in_valid && bus32.in_ready) acc++;
      if (bus32.out_valid) begin
        check("w32_word", 64'(bus32.out_word), 64'(exp32[got]));
        check("w32_idx", 64'(bus32.out_idx), 64'(got));
        check("w32_last", 64'(bus32.out_last), 64'(got == 63));
        cap32[got] = bus32.out_word;
        got++;
      end
      cyc++;
    end
    bus32.in_valid = 1'b0;
    check("run32_complete", 64'(got), 64'd64);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) blk[i] = 64'd0;
    blk[0]  = 64'h6162638000000000;
    blk[15] = 64'h18;
    blk[17] = 64'd1;
    for (int i = 0; i < 16; i++) blk[32+i] = 64'h0123456789ABCDEF * 64'(i + 3);
    for (int i = 0; i < 16; i++) blk[48+i] = ~blk[32+i] ^ 64'(i);
    for (int i = 0; i < 16; i++) blk32[i] = 32'd0;
    blk32[0]  = 32'h61626380;
    blk32[15] = 32'h18;
    build_models();

    bus64.in_valid = 1'b0; bus64.in_word = '0; bus64.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_word = '0; bus32.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus64.out_valid), 64'd0);
    check("rst_out_word", bus64.out_word, 64'd0);
    check("rst_out_idx", 64'(bus64.out_idx), 64'd0);
    check("rst_out_last", 64'(bus64.out_last), 64'd0);
    check("rst_busy", 64'(bus64.busy), 64'd0);
    check("rst_in_ready", 64'(bus64.in_ready), 64'd1);
    check("rst_in_ready32", 64'(bus32.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // SHA-512 "abc", no stalls
    run64(0, 1, 1'b0, -1);
    check("abc_w16", cap[16], 64'h6162638000000000);
    check("abc_w17", cap[17], 64'h00030000000000C0);
    check("abc_80_cycles", 64'(t_last0 - t_first0), 64'd79);

    // sigma0 isolation
    run64(1, 1, 1'b0, -1);
    check("sig0_w16", cap[16], 64'h8100000000000000);

    // random backpressure on "abc"
    run64(0, 1, 1'b1, -1);
    check("stall_w17", cap[17], 64'h00030000000000C0);

    // back-to-back blocks
    run64(2, 2, 1'b0, -1);
    check("b2b_no_bubble", 64'(t_first1 - t_last0), 64'd1);

    // abort mid-EXPAND
    run64(2, 1, 1'b0, 38);
    @(negedge clk);
    check("mid_busy", 64'(bus64.busy), 64'd1);
    bus64.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(bus64.out_valid), 64'd0);
    check("abort_out_word", bus64.out_word, 64'd0);
    check("abort_out_idx", 64'(bus64.out_idx), 64'd0);
    check("abort_out_last", 64'(bus64.out_last), 64'd0);
    check("abort_busy", 64'(bus64.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus64.in_ready), 64'd1);
    run64(3, 1, 1'b0, -1);

    // SHA-256 "abc"
    run32();
    check("abc32_w16", 64'(cap32[16]), 64'h61626380);
    check("abc32_w17", 64'(cap32[17]), 64'h000F0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
